stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear controller for the sprint timer. Generates the 100 Hz time base from the 25 MHz system clock, sequences a 5-digit BCD time counter (M:SS:tt, max 9:59:99), and selects whether the live time or a frozen lap time is presented. Its `disp_d4..disp_d0` outputs feed the 5-digit refresh multiplexer directly. Button inputs arrive already debounced as single-cycle pulses.

---
 rtl/stopwatch_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear controller for a 5-digit BCD sprint timer (M:SS:tt).
// Divides the system clock down to a centisecond tick, counts up to 9:59:99 and saturates.
// Optional lap-freeze feature is built only when STOPWATCH_LAP_EN is defined.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] disp_d4,
  output logic [3:0] disp_d3,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d0,
  output logic       running,
  output logic       lap_active,
  output logic       ovf,
  output logic       tick
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {StIdle, StRun, StPaused, StLap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StPaused} state_e;
`endif

  state_e           r_state;
  logic             r_running;
  logic             r_ovf;
  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_d4, r_d3, r_d2, r_d1, r_d0;

  logic             w_counting;
  logic             w_tick;
  logic             w_at_max;
  logic             w_clr;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [3:0]       w_nd4, w_nd3, w_nd2, w_nd1, w_nd0;
  logic [19:0]      w_live_time;
  logic [19:0]      w_disp;

`ifdef STOPWATCH_LAP_EN
  logic [19:0]      r_lap_time;
  logic             r_lap_active;
  assign w_counting = (r_state == StRun) || (r_state == StLap);
`else
  logic             w_unused_lap;
  assign w_unused_lap = lap;
  assign w_counting   = (r_state == StRun);
`endif

  assign w_tick      = w_counting && (r_pre == PRE_LAST);
  assign w_at_max    = (r_d4 == 4'd9) && (r_d3 == 4'd5) && (r_d2 == 4'd9) &&
                       (r_d1 == 4'd9) && (r_d0 == 4'd9);
  assign w_clr       = (r_state == StPaused) && clear;
  assign w_live_time = {r_d4, r_d3, r_d2, r_d1, r_d0};

  // Prescaler next value: advance while counting, wrap on tick, zero on clear
  always_comb begin
    w_pre_nxt = r_pre;
    if (w_clr || w_tick) begin
      w_pre_nxt = '0;
    end else if (w_counting) begin
      w_pre_nxt = r_pre + 1'b1;
    end
  end

  // Time next value: full BCD ripple on tick, saturating at 9:59:99, zero on clear
  always_comb begin
    {w_nd4, w_nd3, w_nd2, w_nd1, w_nd0} = w_live_time;
    if (w_clr) begin
      {w_nd4, w_nd3, w_nd2, w_nd1, w_nd0} = '0;
    end else if (w_tick && !w_at_max) begin
      if (r_d0 != 4'd9) begin
        w_nd0 = r_d0 + 4'd1;
      end else begin
        w_nd0 = 4'd0;
        if (r_d1 != 4'd9) begin
          w_nd1 = r_d1 + 4'd1;
        end else begin
          w_nd1 = 4'd0;
          if (r_d2 != 4'd9) begin
            w_nd2 = r_d2 + 4'd1;
          end else begin
            w_nd2 = 4'd0;
            if (r_d3 != 4'd5) begin
              w_nd3 = r_d3 + 4'd1;
            end else begin
              w_nd3 = 4'd0;
              w_nd4 = r_d4 + 4'd1;
            end
          end
        end
      end
    end
  end

  // Control FSM with registered status; time and prescaler load their next values every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
      r_pre     <= '0;
      {r_d4, r_d3, r_d2, r_d1, r_d0} <= '0;
`ifdef STOPWATCH_LAP_EN
      r_lap_time   <= '0;
      r_lap_active <= 1'b0;
`endif
    end else begin
      r_pre <= w_pre_nxt;
      {r_d4, r_d3, r_d2, r_d1, r_d0} <= {w_nd4, w_nd3, w_nd2, w_nd1, w_nd0};
      unique case (r_state)
        StIdle: begin
          if (start_stop) begin
            r_state   <= StRun;
            r_running <= 1'b1;
          end
        end
        StRun: begin
          // Saturation wins over any button pressed on the same edge
          if (w_tick && w_at_max) begin
            r_state   <= StPaused;
            r_running <= 1'b0;
            r_ovf     <= 1'b1;
          end else if (start_stop) begin
            r_state   <= StPaused;
            r_running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
          end else if (lap) begin
            r_state      <= StLap;
            r_lap_active <= 1'b1;
            r_lap_time   <= w_live_time;
`endif
          end
        end
`ifdef STOPWATCH_LAP_EN
        StLap: begin
          if (w_tick && w_at_max) begin
            r_state      <= StPaused;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_ovf        <= 1'b1;
          end else if (start_stop) begin
            r_state      <= StPaused;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
          end else if (lap) begin
            r_lap_time <= w_live_time;
          end
        end
`endif
        StPaused: begin
          if (clear) begin
            r_state <= StIdle;
            r_ovf   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            r_lap_time <= '0;
`endif
          end else if (start_stop && !r_ovf) begin
            r_state   <= StRun;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Display select: frozen lap time while in LAP, live time otherwise
  always_comb begin
    w_disp = w_live_time;
`ifdef STOPWATCH_LAP_EN
    if (r_state == StLap) begin
      w_disp = r_lap_time;
    end
`endif
  end

  assign {disp_d4, disp_d3, disp_d2, disp_d1, disp_d0} = w_disp;
  assign running = r_running;
  assign ovf     = r_ovf;
  assign tick    = w_tick;
`ifdef STOPWATCH_LAP_EN
  assign lap_active = r_lap_active;
`else
  assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV = 4.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int unsigned TICK_DIV = 4;
`ifdef STOPWATCH_LAP_EN
  localparam logic [31:0] LIVE_B = 32'h00008;
`else
  localparam logic [31:0] LIVE_B = 32'h00004;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_stop;
  logic        lap;
  logic        clear;
  logic [3:0]  disp_d4, disp_d3, disp_d2, disp_d1, disp_d0;
  logic        running, lap_active, ovf, tick;
  logic [19:0] disp;

  int n_checks;
  int n_errors;
  int tick_total = 0;
  int tick_base;

  assign disp = {disp_d4, disp_d3, disp_d2, disp_d1, disp_d0};

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .disp_d4    (disp_d4),
    .disp_d3    (disp_d3),
    .disp_d2    (disp_d2),
    .disp_d1    (disp_d1),
    .disp_d0    (disp_d0),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // Tick strobes are counted mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (tick === 1'b1) tick_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive buttons for exactly one sampling edge, then return 1 ns after it
  task automatic pulse(input logic ss, input logic lp, input logic cl);
    start_stop = ss;
    lap        = lp;
    clear      = cl;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;

    // Reset state
    #12;
    chk("rst_disp", disp, 0);
    chk("rst_running", running, 0);
    chk("rst_lap_active", lap_active, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // IDLE ignores lap and clear
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    cycles(5);
    chk("idle_running", running, 0);
    chk("idle_lap_active", lap_active, 0);
    chk("idle_disp", disp, 0);
    chk("idle_no_ticks", tick_total, 0);

    // Basic count: 123 ticks -> 0:01:23
    tick_base = tick_total;
    pulse(1, 0, 0);
    chk("start_running", running, 1);
    cycles(492);
    chk("count_disp", disp, 32'h00123);
    chk("count_ticks", tick_total - tick_base, 123);
    chk("count_running", running, 1);
    pulse(1, 0, 0);
    chk("pause_running", running, 0);
    chk("pause_hold", disp, 32'h00123);

    // clear beats start_stop in PAUSED
    pulse(1, 0, 1);
    chk("prio_clr_running", running, 0);
    chk("prio_clr_disp", disp, 0);

    // Pause/resume; prescaler restarts from zero after clear
    tick_base = tick_total;
    pulse(1, 0, 0);
    cycles(2);
    chk("first_tick_early", tick, 0);
    cycles(1);
    chk("first_tick", tick, 1);
    cycles(6);
    pulse(1, 0, 0);
    chk("pause2_disp", disp, 32'h00002);
    chk("pause2_ticks", tick_total - tick_base, 2);
    chk("pause2_running", running, 0);
    tick_base = tick_total;
    cycles(100);
    chk("paused_hold_disp", disp, 32'h00002);
    chk("paused_no_ticks", tick_total - tick_base, 0);
    chk("paused_tick", tick, 0);
    pulse(1, 0, 0);
    chk("resume_tick_early", tick, 0);
    cycles(1);
    chk("resume_tick", tick, 1);
    chk("resume_disp_before", disp, 32'h00002);
    cycles(1);
    chk("resume_disp_after", disp, 32'h00003);

`ifdef STOPWATCH_LAP_EN
    // Lap capture, re-capture on a tick edge, and exit to live display
    cycles(8);
    chk("pre_lap_disp", disp, 32'h00005);
    pulse(0, 1, 0);
    chk("lap_active", lap_active, 1);
    chk("lap_running", running, 1);
    chk("lap_disp", disp, 32'h00005);
    cycles(6);
    chk("lap_frozen", disp, 32'h00005);
    chk("lap_counting_tick", tick, 1);
    pulse(0, 1, 0);
    chk("lap_recapture", disp, 32'h00006);
    chk("lap_still_active", lap_active, 1);
    cycles(4);
    chk("lap_frozen2", disp, 32'h00006);
    pulse(1, 0, 0);
    chk("lap_exit_disp", disp, 32'h00008);
    chk("lap_exit_active", lap_active, 0);
    chk("lap_exit_running", running, 0);
`else
    // Without the lap feature the lap button has no effect
    pulse(0, 1, 0);
    chk("nolap_running", running, 1);
    chk("nolap_active", lap_active, 0);
    chk("nolap_disp", disp, 32'h00003);
    cycles(3);
    chk("nolap_live", disp, 32'h00004);
    pulse(1, 0, 0);
    chk("nolap_pause", running, 0);
`endif

    // start_stop beats lap in RUN
    pulse(1, 0, 0);
    chk("resume2_running", running, 1);
    pulse(1, 1, 0);
    chk("prio_ss_lap_running", running, 0);
    chk("prio_ss_lap_active", lap_active, 0);

    // clear is ignored while running
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    chk("run_clear_running", running, 1);
    chk("run_clear_disp", disp, LIVE_B);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    chk("clear_disp", disp, 0);
    chk("clear_running", running, 0);

    // Overflow: preload 9:59:98 while paused, then count through saturation
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    force dut.r_d4 = 4'd9;
    force dut.r_d3 = 4'd5;
    force dut.r_d2 = 4'd9;
    force dut.r_d1 = 4'd9;
    force dut.r_d0 = 4'd8;
    cycles(1);
    release dut.r_d4;
    release dut.r_d3;
    release dut.r_d2;
    release dut.r_d1;
    release dut.r_d0;
    cycles(1);
    chk("preload_disp", disp, 32'h95998);
    pulse(1, 0, 0);
    cycles(2);
    chk("pre_max_tick", tick, 1);
    cycles(1);
    chk("at_max_disp", disp, 32'h95999);
    chk("at_max_ovf", ovf, 0);
    chk("at_max_running", running, 1);
    cycles(3);
    chk("ovf_tick", tick, 1);
    pulse(0, 1, 0);
    chk("ovf_disp", disp, 32'h95999);
    chk("ovf_flag", ovf, 1);
    chk("ovf_running", running, 0);
    chk("ovf_lap_active", lap_active, 0);
    pulse(1, 0, 0);
    chk("ovf_ss_ignored", running, 0);
    tick_base = tick_total;
    cycles(10);
    chk("ovf_hold_disp", disp, 32'h95999);
    chk("ovf_hold_ticks", tick_total - tick_base, 0);
    chk("ovf_hold_flag", ovf, 1);
    pulse(0, 0, 1);
    chk("ovf_clear_disp", disp, 0);
    chk("ovf_clear_flag", ovf, 0);
    chk("ovf_clear_running", running, 0);

    // Asynchronous reset between edges, mid-count (and mid-lap when built)
    pulse(1, 0, 0);
    cycles(5);
`ifdef STOPWATCH_LAP_EN
    pulse(0, 1, 0);
    chk("pre_rst_lap_active", lap_active, 1);
`endif
    chk("pre_rst_running", running, 1);
    chk("pre_rst_disp", disp, 32'h00001);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_disp", disp, 0);
    chk("arst_running", running, 0);
    chk("arst_lap_active", lap_active, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_tick", tick, 0);
    #2;
    rst_n = 1'b1;
    cycles(3);
    chk("post_rst_running", running, 0);
    chk("post_rst_disp", disp, 0);
    chk("post_rst_tick", tick, 0);
    pulse(1, 0, 0);
    chk("post_rst_start", running, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
